// File: rtl/ariane_prof_pkg.sv
// Shared types for the Ariane issue-stage stall profiler: the counter-bank FSM
// states and the stall-reason codes reported by the issue ports.
package ariane_prof_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SNAP = 2'd2
  } prof_state_e;

  localparam int unsigned STALL_REASON_W = 6;

  // Code 0 also absorbs any out-of-range code seen on an issue port.
  typedef enum logic [STALL_REASON_W-1:0] {
    STALL_UNKNOWN         = 6'd0,
    STALL_ICACHE_MISS     = 6'd1,
    STALL_ITLB_MISS       = 6'd2,
    STALL_DCACHE_MISS     = 6'd3,
    STALL_DTLB_MISS       = 6'd4,
    STALL_RAW_DEP         = 6'd5,
    STALL_WAW_DEP         = 6'd6,
    STALL_FU_BUSY         = 6'd7,
    STALL_LSU_FULL        = 6'd8,
    STALL_SCOREBOARD_FULL = 6'd9,
    STALL_BRANCH_FLUSH    = 6'd10,
    STALL_CSR_SERIAL      = 6'd11,
    STALL_FENCE           = 6'd12,
    STALL_AMO             = 6'd13,
    STALL_DIV_BUSY        = 6'd14,
    STALL_FPU_BUSY        = 6'd15
  } stall_reason_e;

endpackage

// File: rtl/ariane_prof_sat_ctr.sv
// One saturating event counter with a multi-bit increment and a sticky
// overflow bit; also exposes the post-increment value for snapshot capture.
module ariane_prof_sat_ctr #(
  parameter int unsigned width_p     = 64,
  parameter int unsigned inc_width_p = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   load_zero_i,
  input  logic [inc_width_p-1:0] inc_i,
  output logic [width_p-1:0]     cnt_o,
  output logic                   ovf_o,
  output logic [width_p-1:0]     sum_o,
  output logic                   sum_ovf_o
);

  logic [width_p:0] raw_sum;

  // The carry out marks increments that could not be represented.
  assign raw_sum   = {1'b0, cnt_o} + (width_p + 1)'(inc_i);
  assign sum_o     = raw_sum[width_p] ? '1 : raw_sum[width_p-1:0];
  assign sum_ovf_o = ovf_o | raw_sum[width_p];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_o <= '0;
      ovf_o <= 1'b0;
    end else if (clear_i || load_zero_i) begin
      cnt_o <= '0;
      ovf_o <= 1'b0;
    end else begin
      cnt_o <= sum_o;
      ovf_o <= sum_ovf_o;
    end
  end

endmodule

// File: rtl/ariane_stall_counter_bank.sv
// Bank of per-reason stall counters with a windowed snapshot (shadow) bank
// and a single-cycle-latency read port.
module ariane_stall_counter_bank
  import ariane_prof_pkg::*;
#(
  parameter  int unsigned num_reasons_p   = 35,
  parameter  int unsigned num_ports_p     = 2,
  parameter  int unsigned width_p         = 64,
  parameter  int unsigned window_width_p  = 32,
  localparam int unsigned reason_width_lp = $clog2(num_reasons_p),
  localparam int unsigned inc_width_lp    = $clog2(num_ports_p + 1)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   en_i,
  input  logic                                   clear_i,
  input  logic                                   window_mode_i,
  input  logic [window_width_p-1:0]              window_len_i,
  input  logic [num_ports_p-1:0]                 stall_v_i,
  input  logic [num_ports_p*reason_width_lp-1:0] stall_reason_i,
  input  logic                                   rd_v_i,
  input  logic [reason_width_lp-1:0]             rd_addr_i,
  input  logic                                   rd_shadow_i,
  output logic                                   rd_v_o,
  output logic [width_p-1:0]                     rd_data_o,
  output logic                                   rd_ovf_o,
  output logic                                   snap_v_o,
  output logic                                   bad_code_o
);

  prof_state_e               state, state_next;
  logic [window_width_p-1:0] win_cnt, win_next, win_last;
  logic                      snap_fire;
  logic                      bad_seen;

  logic [reason_width_lp-1:0] code       [num_ports_p];
  logic [inc_width_lp-1:0]    inc        [num_reasons_p];
  logic [width_p-1:0]         live_cnt   [num_reasons_p];
  logic [width_p-1:0]         live_sum   [num_reasons_p];
  logic                       live_ovf   [num_reasons_p];
  logic                       live_sovf  [num_reasons_p];
  logic [width_p-1:0]         shadow_cnt [num_reasons_p];
  logic                       shadow_ovf [num_reasons_p];
  logic [width_p-1:0]         rd_sel_data;
  logic                       rd_sel_ovf;

  // Out-of-range codes fold into reason 0 and raise the bad-code flag.
  always_comb begin
    bad_seen = 1'b0;
    for (int p = 0; p < num_ports_p; p++) begin
      code[p] = stall_reason_i[p*reason_width_lp +: reason_width_lp];
      if (32'(code[p]) >= num_reasons_p) begin
        code[p]  = '0;
        bad_seen = bad_seen | (en_i & stall_v_i[p]);
      end
    end
    for (int k = 0; k < num_reasons_p; k++) begin
      inc[k] = '0;
      for (int p = 0; p < num_ports_p; p++) begin
        if (en_i && stall_v_i[p] && code[p] == reason_width_lp'(k)) begin
          inc[k] = inc[k] + 1'b1;
        end
      end
    end
  end

  assign win_last  = (window_len_i == '0) ? '0 : window_len_i - 1'b1;
  assign snap_fire = (state == RUN) && en_i && window_mode_i && !clear_i &&
                     (win_cnt >= win_last);

  always_comb begin
    state_next = state;
    win_next   = win_cnt;
    case (state)
      IDLE:    if (en_i) state_next = RUN;
      RUN:     if (!en_i) state_next = IDLE;
               else if (snap_fire) state_next = SNAP;
      SNAP:    state_next = en_i ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
    if (!window_mode_i || snap_fire) begin
      win_next = '0;
    end else if (en_i && win_cnt < win_last) begin
      win_next = win_cnt + 1'b1;
    end
    if (clear_i) begin
      state_next = IDLE;
      win_next   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      win_cnt    <= '0;
      bad_code_o <= 1'b0;
    end else begin
      state   <= state_next;
      win_cnt <= win_next;
      if (clear_i) bad_code_o <= 1'b0;
      else if (bad_seen) bad_code_o <= 1'b1;
    end
  end

  for (genvar k = 0; k < num_reasons_p; k++) begin : g_ctr
    ariane_prof_sat_ctr #(
      .width_p    (width_p),
      .inc_width_p(inc_width_lp)
    ) u_ctr (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clear_i    (clear_i),
      .load_zero_i(snap_fire),
      .inc_i      (inc[k]),
      .cnt_o      (live_cnt[k]),
      .ovf_o      (live_ovf[k]),
      .sum_o      (live_sum[k]),
      .sum_ovf_o  (live_sovf[k])
    );
  end

  // The shadow bank captures live values including the closing cycle's events.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < num_reasons_p; k++) begin
        shadow_cnt[k] <= '0;
        shadow_ovf[k] <= 1'b0;
      end
    end else if (snap_fire) begin
      for (int k = 0; k < num_reasons_p; k++) begin
        shadow_cnt[k] <= live_sum[k];
        shadow_ovf[k] <= live_sovf[k];
      end
    end
  end

  always_comb begin
    rd_sel_data = '0;
    rd_sel_ovf  = 1'b0;
    for (int k = 0; k < num_reasons_p; k++) begin
      if (rd_addr_i == reason_width_lp'(k)) begin
        rd_sel_data = rd_shadow_i ? shadow_cnt[k] : live_cnt[k];
        rd_sel_ovf  = rd_shadow_i ? shadow_ovf[k] : live_ovf[k];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_v_o    <= 1'b0;
      rd_data_o <= '0;
      rd_ovf_o  <= 1'b0;
    end else begin
      rd_v_o    <= rd_v_i;
      rd_data_o <= rd_v_i ? rd_sel_data : '0;
      rd_ovf_o  <= rd_v_i & rd_sel_ovf;
    end
  end

  assign snap_v_o = (state == SNAP);

endmodule

// File: doc/ariane_stall_counter_bank.md
ARIANE_STALL_COUNTER_BANK -- requirements
Module: ariane_stall_counter_bank

Interface
REQ-001 SHALL have parameter num_reasons_p, default 35, number of stall-reason codes counted (code 0 = unknown).
REQ-002 SHALL have parameter num_ports_p, default 2, issue ports reporting a reason each cycle.
REQ-003 SHALL have parameter width_p, default 64, counter width.
REQ-004 SHALL have parameter window_width_p, default 32, width of the sampling-window length.
REQ-005 SHALL use one clock and an asynchronous active-low reset, with ports ordered as in REQ-006 and REQ-007.
REQ-006 SHALL have clk_i  input  1  sole clock, all state on rising edge.
REQ-007 SHALL have rst_ni  input  1  asynchronous active-low reset.
REQ-008 SHALL have en_i  input  1  counting enable.
REQ-009 SHALL have clear_i  input  1  synchronous clear of live counters, sticky bits and window count.
REQ-010 SHALL have window_mode_i  input  1  0 = free-running, 1 = windowed snapshots.
REQ-011 SHALL have window_len_i  input  window_width_p  window length in enabled cycles; 0 treated as 1.
REQ-012 SHALL have stall_v_i  input  num_ports_p  per-port stall valid.
REQ-013 SHALL have stall_reason_i  input  num_ports_p*R  per-port reason code, R = clog2(num_reasons_p), port 0 in LSBs.
REQ-014 SHALL have rd_v_i  input  1  read request.
REQ-015 SHALL have rd_addr_i  input  R  reason to read.
REQ-016 SHALL have rd_shadow_i  input  1  1 = read snapshot bank, 0 = live bank.
REQ-017 SHALL have rd_v_o  output  1  read data valid.
REQ-018 SHALL have rd_data_o  output  width_p  read count.
REQ-019 SHALL have rd_ovf_o  output  1  sticky saturation flag of the addressed reason in the selected bank.
REQ-020 SHALL have snap_v_o  output  1  one-cycle pulse when the snapshot bank updates.
REQ-021 SHALL have bad_code_o  output  1  sticky flag: out-of-range code observed.

Function
REQ-022 Each cycle with en_i=1, live counter k SHALL increase by the number of ports with stall_v_i=1 and code k (0..num_ports_p), visible the next cycle.
REQ-023 A code >= num_reasons_p with valid=1 SHALL count as reason 0 and set bad_code_o the next cycle.
REQ-024 Counters SHALL saturate at 2**width_p-1 and set that reason's sticky ovf bit, never wrapping.
REQ-025 The FSM SHALL have states IDLE, RUN and SNAP, with IDLE the reset state.
REQ-026 IDLE->RUN on en_i=1.
REQ-027 RUN->IDLE on en_i=0.
REQ-028 RUN->SNAP when window_mode_i=1 and the window count reaches window_len_i-1 on an enabled cycle.
REQ-029 SNAP->RUN if en_i=1, else SNAP->IDLE.
REQ-030 On entering SNAP, the shadow bank and its ovf bits SHALL capture the live values including that cycle's increments, snap_v_o SHALL pulse during SNAP, and live counters, live ovf and window count SHALL restart from that SNAP cycle's increments.
REQ-031 In free-running mode the window count SHALL hold at 0 and no snapshot SHALL occur.
REQ-032 The window count SHALL hold while en_i=0; snapshots SHALL occur only on enabled cycles.
REQ-033 clear_i SHALL zero live counters, live ovf, bad_code_o and window count, discard that cycle's increments, and go to IDLE; the shadow bank SHALL be untouched.
REQ-034 clear_i and the snapshot condition in the same cycle: clear SHALL win and no snapshot SHALL occur.
REQ-035 Reads SHALL have fixed 1-cycle latency: rd_v_o follows rd_v_i, and data is the bank value before the same-cycle update.
REQ-036 A read with rd_addr_i >= num_reasons_p SHALL return 0 with rd_ovf_o=0.
REQ-037 Reads SHALL never stall or alter counting.

Reset
REQ-038 On rst_ni=0, all counters, ovf bits, window count, rd_data_o, rd_v_o, rd_ovf_o, snap_v_o and bad_code_o SHALL be 0 and the FSM SHALL be in IDLE, asynchronously.
REQ-039 Deassertion of rst_ni SHALL take effect on the next clk_i edge, and assertion mid-window SHALL discard the partial window.

Structure
REQ-040 The package ariane_prof_pkg SHALL hold the FSM state enum (IDLE, RUN, SNAP) and the stall-reason enum shared with the issue profiler.
REQ-041 Exactly one sub-module, ariane_prof_sat_ctr, SHALL implement one saturating counter with multi-bit increment, sticky ovf, clear and load-zero, instantiated num_reasons_p times.

Verification
REQ-042 ports=2, both ports code 5 for 10 enabled cycles -> live[5]=20, all other counters 0.
REQ-043 window_len=8, port0 code 3 every cycle -> snap_v_o every 8th cycle, shadow[3]=8, live[3] restarts at 1 after the pulse.
REQ-044 width_p=4, code 1 on both ports for 9 cycles -> live[1]=15, ovf set, no wrap.
REQ-045 Code 40 with num_reasons_p=35 -> live[0] increments, bad_code_o=1 until clear_i.
REQ-046 clear_i on the snapshot cycle -> no snap_v_o, shadow unchanged, live=0.
REQ-047 rst_ni pulsed mid-window while a read is pending -> all outputs 0 immediately, FSM IDLE, rd_v_o=0.
